// File: rtl/fp_pkg.sv
// Shared GF(q^2) constants and the squaring-chain FSM state encoding.
package fp_pkg;

    localparam int FP_W = 255;

    localparam logic [FP_W-1:0] Q =
        255'd2261564242916331941866620800950935700259179388000792266395655937654553313279;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fp2_sqr.sv
// Fixed-latency (3 cycles) Fp2 squarer: D1 = (A1+B1)(A1-B1) mod q, D2 = 2*A1*B1 mod q.
module fp2_sqr
    import fp_pkg::*;
(
    input  logic            clk,
    input  logic [FP_W-1:0] A1,
    input  logic [FP_W-1:0] B1,
    output logic [FP_W-1:0] D1,
    output logic [FP_W-1:0] D2
);

    localparam int PW = 2 * FP_W;
    localparam logic [PW-1:0] QP = PW'(Q);

    logic [FP_W-1:0] w_sum;
    logic [FP_W-1:0] w_dif;
    logic [FP_W-1:0] r_s;
    logic [FP_W-1:0] r_d;
    logic [FP_W-1:0] r_a;
    logic [FP_W-1:0] r_b;
    logic [PW-1:0]   r_p_re;
    logic [PW-1:0]   r_p_im;
    logic [FP_W-1:0] r_d1;
    logic [FP_W-1:0] r_d2;

    // q is well below 2^(FP_W-1), so A1+B1 and A1+q-B1 cannot overflow FP_W bits.
    always_comb begin
        w_sum = A1 + B1;
        if (w_sum >= Q) begin
            w_sum = w_sum - Q;
        end
        w_dif = (A1 >= B1) ? (A1 - B1) : (A1 + Q - B1);
    end

    always_ff @(posedge clk) begin
        r_s    <= w_sum;
        r_d    <= w_dif;
        r_a    <= A1;
        r_b    <= B1;
        r_p_re <= PW'(r_s) * PW'(r_d);
        r_p_im <= (PW'(r_a) * PW'(r_b)) << 1;
        r_d1   <= FP_W'(r_p_re % QP);
        r_d2   <= FP_W'(r_p_im % QP);
    end

    assign D1 = r_d1;
    assign D2 = r_d2;

endmodule

// File: rtl/fp2_sqr_chain.sv
// Repeated Fp2 squaring sequencer: d = a^(2^n). Optional abort input under FP2_SQR_CHAIN_ABORT_EN.
module fp2_sqr_chain #(
    parameter int FP_W    = 255,
    parameter int NW      = 9,
    parameter int SQR_LAT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [NW-1:0]   n,
    input  logic [FP_W-1:0] a_re,
    input  logic [FP_W-1:0] a_im,
`ifdef FP2_SQR_CHAIN_ABORT_EN
    input  logic            abort,
`endif
    output logic            busy,
    output logic            done,
    output logic [FP_W-1:0] d_re,
    output logic [FP_W-1:0] d_im
);
    import fp_pkg::*;

    localparam int WCW = (SQR_LAT > 1) ? $clog2(SQR_LAT) : 1;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [FP_W-1:0] r_op_re;
    logic [FP_W-1:0] r_op_im;
    logic [NW-1:0]   r_rem;
    logic [WCW-1:0]  r_wcnt;
    logic            r_busy;
    logic            r_done;
    logic [FP_W-1:0] r_d_re;
    logic [FP_W-1:0] r_d_im;
    logic [FP_W-1:0] w_sq_re;
    logic [FP_W-1:0] w_sq_im;
    logic            w_abort;
    logic            w_wrap;
    logic            w_load;
    logic            w_step;
    logic            w_kill;
    logic            w_finish;

`ifdef FP2_SQR_CHAIN_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_wrap = (r_wcnt == WCW'(SQR_LAT - 1));

    fp2_sqr u_sqr (
        .clk (clk),
        .A1  (r_op_re),
        .B1  (r_op_im),
        .D1  (w_sq_re),
        .D2  (w_sq_im)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = (n == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_abort) begin
                    w_state_nxt = IDLE;
                end else if (w_wrap && (r_rem == NW'(1))) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_load   = (r_state == IDLE) && start;
        w_kill   = (r_state == RUN) && w_abort;
        w_step   = (r_state == RUN) && !w_abort && w_wrap;
        w_finish = (r_state == DONE);
    end

    // The operand registers hold still for a whole SQR_LAT window, so the squarer output is settled at capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_re <= '0;
            r_op_im <= '0;
            r_rem   <= '0;
            r_wcnt  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_d_re  <= '0;
            r_d_im  <= '0;
        end else begin
            r_done <= w_finish;
            if (w_load) begin
                r_op_re <= a_re;
                r_op_im <= a_im;
                r_rem   <= n;
                r_wcnt  <= '0;
                r_busy  <= 1'b1;
            end
            if (r_state == RUN) begin
                if (w_kill) begin
                    r_wcnt <= '0;
                    r_busy <= 1'b0;
                end else if (w_step) begin
                    r_op_re <= w_sq_re;
                    r_op_im <= w_sq_im;
                    r_rem   <= r_rem - NW'(1);
                    r_wcnt  <= '0;
                end else begin
                    r_wcnt <= r_wcnt + WCW'(1);
                end
            end
            if (w_finish) begin
                r_d_re <= r_op_re;
                r_d_im <= r_op_im;
                r_busy <= 1'b0;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign d_re = r_d_re;
    assign d_im = r_d_im;

endmodule
